pc_gen_unit: RTL and testbench

//  Parametrised PC register plus next-PC generator for the pipelined CPU; successor to the single-cycle next-PC logic.

---
 rtl/pc_gen_unit_pkg.sv | 21 ++
 rtl/pc_gen_unit_npc_target.sv | 57 +++++
 rtl/pc_gen_unit.sv | 98 +++++++++
 tb/tb_pc_gen_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_unit_pkg.sv
// Shared types for the fetch PC generator: next-PC op codes and FSM states.
package pc_gen_unit_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned IMM_W = 26;

    // Unlisted op codes fall through as PLUS4.
    typedef enum logic [OP_W-1:0] {
        NPC_PLUS4  = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JR     = 3'd3,
        NPC_ERET   = 3'd4
    } npc_op_e;

    typedef enum logic {
        ST_SEQ     = 1'b0,
        ST_PENDING = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen_unit_npc_target.sv
// Combinational redirect target plus misaligned-register-target flag.
module pc_gen_unit_npc_target
    import pc_gen_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op_valid_i,
    input  logic [OP_W-1:0]  npc_op_i,
    input  logic [WIDTH-1:0] src_pc_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [WIDTH-1:0] reg_i,
    input  logic [WIDTH-1:0] epc_i,
    output logic             redir_c_o,
    output logic             eret_c_o,
    output logic             misalign_c_o,
    output logic [WIDTH-1:0] target_c_o
);

    logic [WIDTH-1:0] p4;
    logic [WIDTH-1:0] br_off;

    assign p4     = src_pc_i + WIDTH'(4);
    assign br_off = {{(WIDTH-18){imm_i[15]}}, imm_i[15:0], 2'b00};

    // Only register-sourced targets (JR/ERET) can be misaligned.
    always_comb begin
        redir_c_o    = 1'b0;
        eret_c_o     = 1'b0;
        misalign_c_o = 1'b0;
        target_c_o   = p4;
        if (op_valid_i) begin
            case (npc_op_i)
                NPC_BRANCH: begin
                    redir_c_o  = 1'b1;
                    target_c_o = p4 + br_off;
                end
                NPC_JUMP: begin
                    redir_c_o  = 1'b1;
                    target_c_o = {p4[WIDTH-1:28], imm_i, 2'b00};
                end
                NPC_JR: begin
                    redir_c_o    = 1'b1;
                    target_c_o   = reg_i;
                    misalign_c_o = |reg_i[1:0];
                end
                NPC_ERET: begin
                    redir_c_o    = 1'b1;
                    eret_c_o     = 1'b1;
                    target_c_o   = epc_i;
                    misalign_c_o = |epc_i[1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register with redirect, exception vectoring, EPC capture and optional delay slot.
module pc_gen_unit
    import pc_gen_unit_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_4180),
    parameter int unsigned      DELAY_SLOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             op_valid_i,
    input  logic [OP_W-1:0]  npc_op_i,
    input  logic [WIDTH-1:0] src_pc_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [WIDTH-1:0] reg_i,
    input  logic             exc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             flush_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             addr_err_o
);

    pc_state_e        state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] pend_tgt_q;
    logic             flush_q;
    logic             addr_err_q;

    logic             redir_c;
    logic             eret_c;
    logic             misalign_c;
    logic [WIDTH-1:0] target_c;

    pc_gen_unit_npc_target #(.WIDTH(WIDTH)) u_npc_target (
        .op_valid_i   (op_valid_i),
        .npc_op_i     (npc_op_i),
        .src_pc_i     (src_pc_i),
        .imm_i        (imm_i),
        .reg_i        (reg_i),
        .epc_i        (epc_q),
        .redir_c_o    (redir_c),
        .eret_c_o     (eret_c),
        .misalign_c_o (misalign_c),
        .target_c_o   (target_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEQ;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            pend_tgt_q <= '0;
            flush_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            flush_q    <= 1'b0;
            addr_err_q <= 1'b0;
            if (exc_i) begin
                pc_q    <= EXC_VEC;
                epc_q   <= src_pc_i;
                flush_q <= 1'b1;
                state_q <= ST_SEQ;
            end else if (misalign_c) begin
                pc_q       <= EXC_VEC;
                epc_q      <= target_c;
                flush_q    <= 1'b1;
                addr_err_q <= 1'b1;
                state_q    <= ST_SEQ;
            end else if (stall_i) begin
                // Hold everything; the producer re-presents any redirect.
            end else if (state_q == ST_PENDING) begin
                // Slot already fetched; redirects issued from the slot are ignored.
                pc_q    <= pend_tgt_q;
                state_q <= ST_SEQ;
            end else if (redir_c) begin
                if ((DELAY_SLOT != 0) && !eret_c) begin
                    pend_tgt_q <= target_c;
                    pc_q       <= pc_q + WIDTH'(4);
                    state_q    <= ST_PENDING;
                end else begin
                    pc_q    <= target_c;
                    flush_q <= 1'b1;
                end
            end else begin
                pc_q <= pc_q + WIDTH'(4);
            end
        end
    end

    assign pc_o       = pc_q;
    assign flush_o    = flush_q;
    assign epc_o      = epc_q;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: DS=0, DS=1 and wrap-reset instances driven in lockstep.
module tb_pc_gen_unit;
    import pc_gen_unit_pkg::*;

    logic        clk, rst, stall, op_valid, exc;
    logic [2:0]  npc_op;
    logic [31:0] src_pc, reg_v;
    logic [25:0] imm;

    logic [31:0] pc0, epc0, pc1, epc1, pc2, epc2;
    logic        fl0, ae0, fl1, ae1, fl2, ae2;

    pc_gen_unit #(.DELAY_SLOT(0)) dut0 (
        .clk(clk), .rst(rst), .stall_i(stall), .op_valid_i(op_valid), .npc_op_i(npc_op),
        .src_pc_i(src_pc), .imm_i(imm), .reg_i(reg_v), .exc_i(exc),
        .pc_o(pc0), .flush_o(fl0), .epc_o(epc0), .addr_err_o(ae0));

    pc_gen_unit #(.DELAY_SLOT(1)) dut1 (
        .clk(clk), .rst(rst), .stall_i(stall), .op_valid_i(op_valid), .npc_op_i(npc_op),
        .src_pc_i(src_pc), .imm_i(imm), .reg_i(reg_v), .exc_i(exc),
        .pc_o(pc1), .flush_o(fl1), .epc_o(epc1), .addr_err_o(ae1));

    pc_gen_unit #(.RESET_PC(32'hFFFF_FFFC), .DELAY_SLOT(1)) dut2 (
        .clk(clk), .rst(rst), .stall_i(stall), .op_valid_i(op_valid), .npc_op_i(npc_op),
        .src_pc_i(src_pc), .imm_i(imm), .reg_i(reg_v), .exc_i(exc),
        .pc_o(pc2), .flush_o(fl2), .epc_o(epc2), .addr_err_o(ae2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] pc;
        logic        fl;
        logic [31:0] epc;
        logic        ae;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [65:0] obs(input int sel);
        case (sel)
            0:       return {pc0, fl0, epc0, ae0};
            1:       return {pc1, fl1, epc1, ae1};
            default: return {pc2, fl2, epc2, ae2};
        endcase
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] pc,
                        input logic fl, input logic [31:0] epc, input logic ae);
        exp_t e;
        e.name = name; e.sel = sel; e.pc = pc; e.fl = fl; e.epc = epc; e.ae = ae;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] src,
                         input logic [25:0] im, input logic [31:0] rg, input logic ex,
                         input logic st);
        op_valid = v; npc_op = op; src_pc = src; imm = im; reg_v = rg; exc = ex; stall = st;
    endtask

    task automatic idle();
        drive(1'b0, NPC_PLUS4, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [65:0] got;
        for (int i = 0; i < 4; i++) begin
            rst = (i == 0);
            idle();
            push("reset_seq_ds0", 0, 32'(32'h3000 + 4 * i), 1'b0, 32'h0, 1'b0);
            push("reset_seq_ds1", 1, 32'(32'h3000 + 4 * i), 1'b0, 32'h0, 1'b0);
            push("reset_wrap",    2, 32'(32'hFFFF_FFFC + 4 * i), 1'b0, 32'h0, 1'b0);
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_branch();
        exp_t e;
        logic [65:0] got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1'b1, NPC_BRANCH, 32'h3010, 26'h000FFFE, 32'h0, 1'b0, 1'b0);
                    push("branch_ds0", 0, 32'h300C, 1'b1, 32'h0, 1'b0);
                    push("branch_ds1_slot", 1, 32'h3004, 1'b0, 32'h0, 1'b0);
                end
                1: begin
                    idle();
                    push("branch_ds0_flush_drop", 0, 32'h3010, 1'b0, 32'h0, 1'b0);
                    push("branch_ds1_tgt", 1, 32'h300C, 1'b0, 32'h0, 1'b0);
                end
                default: begin
                    idle();
                    push("branch_ds0_seq", 0, 32'h3014, 1'b0, 32'h0, 1'b0);
                    push("branch_ds1_seq", 1, 32'h3010, 1'b0, 32'h0, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
    endtask

    task automatic test_jump_stall();
        exp_t e;
        logic [65:0] got;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin
                    drive(1'b1, NPC_JUMP, 32'h3000, 26'h0000C40, 32'h0, 1'b0, 1'b0);
                    push("jump_ds1_slot", 1, 32'h3004, 1'b0, 32'h0, 1'b0);
                    push("jump_ds0", 0, 32'h3100, 1'b1, 32'h0, 1'b0);
                end
                1, 2: begin
                    drive(1'b0, NPC_PLUS4, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1);
                    push("stall_pending_hold", 1, 32'h3004, 1'b0, 32'h0, 1'b0);
                    push("stall_ds0_hold", 0, 32'h3100, 1'b0, 32'h0, 1'b0);
                end
                3: begin
                    idle();
                    push("jump_ds1_tgt", 1, 32'h3100, 1'b0, 32'h0, 1'b0);
                    push("jump_ds0_seq", 0, 32'h3104, 1'b0, 32'h0, 1'b0);
                end
                default: begin
                    idle();
                    push("jump_ds1_seq", 1, 32'h3104, 1'b0, 32'h0, 1'b0);
                    push("jump_ds0_seq2", 0, 32'h3108, 1'b0, 32'h0, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        logic [65:0] got;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive(1'b1, NPC_JR, 32'h3010, 26'h0, 32'h3022, 1'b0, 1'b0);
                for (int s = 0; s < 2; s++)
                    push("jr_misalign_trap", s, 32'h4180, 1'b1, 32'h3022, 1'b1);
            end else begin
                idle();
                for (int s = 0; s < 2; s++)
                    push("jr_misalign_after", s, 32'h4184, 1'b0, 32'h3022, 1'b0);
            end
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
    endtask

    task automatic test_exc_eret();
        exp_t e;
        logic [65:0] got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1'b0, NPC_PLUS4, 32'h3040, 26'h0, 32'h0, 1'b1, 1'b1);
                    for (int s = 0; s < 2; s++)
                        push("exc_under_stall", s, 32'h4180, 1'b1, 32'h3040, 1'b0);
                end
                1: begin
                    drive(1'b1, NPC_ERET, 32'h4180, 26'h0, 32'h0, 1'b0, 1'b0);
                    for (int s = 0; s < 2; s++)
                        push("eret_return", s, 32'h3040, 1'b1, 32'h3040, 1'b0);
                end
                default: begin
                    idle();
                    for (int s = 0; s < 2; s++)
                        push("eret_seq", s, 32'h3044, 1'b0, 32'h3040, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_in_pending();
        exp_t e;
        logic [65:0] got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rst = (i == 1);
            case (i)
                0: begin
                    drive(1'b1, NPC_JUMP, 32'h0, 26'h0000400, 32'h0, 1'b0, 1'b0);
                    push("pend_wrap_slot", 2, 32'h0, 1'b0, 32'h0, 1'b0);
                    push("pend_slot_ds1", 1, 32'h3004, 1'b0, 32'h0, 1'b0);
                end
                1: begin
                    idle();
                    push("pend_reset_wrap", 2, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
                    push("pend_reset_ds1", 1, 32'h3000, 1'b0, 32'h0, 1'b0);
                end
                default: begin
                    idle();
                    push("pend_dropped_wrap", 2, 32'(4 * (i - 2)), 1'b0, 32'h0, 1'b0);
                    push("pend_dropped_ds1", 1, 32'(32'h3004 + 4 * (i - 2)), 1'b0, 32'h0, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [65:0] got;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    drive(1'b1, NPC_BRANCH, 32'h3000, 26'h0000010, 32'h0, 1'b0, 1'b0);
                    push("b2b_ds0_branch", 0, 32'h3044, 1'b1, 32'h0, 1'b0);
                    push("b2b_ds1_slot", 1, 32'h3004, 1'b0, 32'h0, 1'b0);
                end
                1: begin
                    drive(1'b1, NPC_JUMP, 32'h3044, 26'h0000800, 32'h0, 1'b0, 1'b0);
                    push("b2b_ds0_jump", 0, 32'h2000, 1'b1, 32'h0, 1'b0);
                    push("b2b_ds1_slot_ignores", 1, 32'h3044, 1'b0, 32'h0, 1'b0);
                end
                default: begin
                    idle();
                    push("b2b_ds0_seq", 0, 32'h2004, 1'b0, 32'h0, 1'b0);
                    push("b2b_ds1_seq", 1, 32'h3048, 1'b0, 32'h0, 1'b0);
                end
            endcase
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_chk++;
                if (got !== {e.pc, e.fl, e.epc, e.ae})
                    $display("FAIL %s dut%0d cyc%0d: got pc=%h fl=%b epc=%h ae=%b, expected pc=%h fl=%b epc=%h ae=%b",
                             e.name, e.sel, i, got[65:34], got[33], got[32:1], got[0], e.pc, e.fl, e.epc, e.ae);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        test_reset();
        test_branch();
        test_jump_stall();
        test_misalign();
        test_exc_eret();
        test_reset_in_pending();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
